// File: rtl/irq_priority_arbiter.sv
// Level-interrupt gateway and priority arbiter with a claim/complete handshake.
// Serves one outstanding interrupt at a time and presents the best eligible source to the core.
module irq_priority_arbiter #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int ID_W   = 4
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [N_SRC-1:0]          src_level,
    input  logic [N_SRC-1:0]          src_enable,
    input  logic [N_SRC*PRIO_W-1:0]   src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim,
    input  logic                      complete,
    input  logic [ID_W-1:0]           complete_id,
    output logic                      irq,
    output logic [ID_W-1:0]           claim_id,
    output logic [ID_W-1:0]           active_id,
    output logic [N_SRC-1:0]          pending,
    output logic                      cmpl_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              state_reg;
    logic                irq_reg;
    logic [ID_W-1:0]     claim_id_reg;
    logic [ID_W-1:0]     active_id_reg;
    logic [N_SRC-1:0]    pending_reg;
    logic [N_SRC-1:0]    pending_next;
    logic                cmpl_err_reg;

    logic [N_SRC-1:0]    eligible;
    logic [N_SRC-1:0]    set_vec;
    logic [N_SRC-1:0]    clr_vec;
    logic                claim_accept;
    logic [ID_W-1:0]     winner;
    logic [PRIO_W-1:0]   best_prio;

    assign claim_accept = (state_reg == REQ) && claim;

    // The source in service is masked from the gateway so a held level is not delivered twice.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign eligible[gi]     = pending_reg[gi] && src_enable[gi] &&
                                      (src_prio[(gi+1)*PRIO_W-1 -: PRIO_W] > threshold);
            assign set_vec[gi]      = src_level[gi] && !pending_reg[gi] &&
                                      (active_id_reg != ID_W'(gi + 1));
            assign clr_vec[gi]      = claim_accept && (claim_id_reg == ID_W'(gi + 1));
            assign pending_next[gi] = (pending_reg[gi] || set_vec[gi]) && !clr_vec[gi];
        end
    endgenerate

    // Ascending scan with a strict compare keeps the lowest ID on priority ties.
    always_comb begin
        winner    = '0;
        best_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && (src_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                winner    = ID_W'(i + 1);
                best_prio = src_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            irq_reg       <= 1'b0;
            claim_id_reg  <= '0;
            active_id_reg <= '0;
            pending_reg   <= '0;
            cmpl_err_reg  <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            cmpl_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (complete) begin
                        cmpl_err_reg <= 1'b1;
                    end
                    if (winner != '0) begin
                        state_reg    <= REQ;
                        irq_reg      <= 1'b1;
                        claim_id_reg <= winner;
                    end
                end
                REQ: begin
                    if (complete) begin
                        cmpl_err_reg <= 1'b1;
                    end
                    // The CPU is granted the ID it saw this cycle, even if the winner just changed.
                    if (claim) begin
                        state_reg     <= SERVICE;
                        active_id_reg <= claim_id_reg;
                        irq_reg       <= 1'b0;
                        claim_id_reg  <= '0;
                    end else if (winner == '0) begin
                        state_reg    <= IDLE;
                        irq_reg      <= 1'b0;
                        claim_id_reg <= '0;
                    end else begin
                        claim_id_reg <= winner;
                    end
                end
                SERVICE: begin
                    if (complete) begin
                        if (complete_id == active_id_reg) begin
                            state_reg     <= IDLE;
                            active_id_reg <= '0;
                        end else begin
                            cmpl_err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign irq       = irq_reg;
    assign claim_id  = claim_id_reg;
    assign active_id = active_id_reg;
    assign pending   = pending_reg;
    assign cmpl_err  = cmpl_err_reg;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked against a
// transaction-level model of the gateway, priority selection and claim/complete protocol.
module tb_irq_priority_arbiter;

    localparam int N_SRC  = 8;
    localparam int PRIO_W = 3;
    localparam int ID_W   = 4;
    localparam int PW     = N_SRC * PRIO_W;
    localparam int VW     = 2 * ID_W + N_SRC + 2;

    logic               CLK = 1'b0;
    logic               nRST = 1'b0;
    logic [N_SRC-1:0]   src_level = '0;
    logic [N_SRC-1:0]   src_enable = '0;
    logic [PW-1:0]      src_prio = '0;
    logic [PRIO_W-1:0]  threshold = '0;
    logic               claim = 1'b0;
    logic               complete = 1'b0;
    logic [ID_W-1:0]    complete_id = '0;
    logic               irq;
    logic [ID_W-1:0]    claim_id;
    logic [ID_W-1:0]    active_id;
    logic [N_SRC-1:0]   pending;
    logic               cmpl_err;

    int tests_run = 0;
    int tests_failed = 0;

    irq_priority_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
        .CLK(CLK), .nRST(nRST), .src_level(src_level), .src_enable(src_enable),
        .src_prio(src_prio), .threshold(threshold), .claim(claim), .complete(complete),
        .complete_id(complete_id), .irq(irq), .claim_id(claim_id), .active_id(active_id),
        .pending(pending), .cmpl_err(cmpl_err)
    );

    always #5 CLK = ~CLK;

    wire [VW-1:0] dut_vec = {irq, claim_id, active_id, pending, cmpl_err};

    // Reference model: "in service" means an ID is held, "requesting" means irq is up.
    logic [N_SRC-1:0] m_pend;
    logic             m_irq;
    logic             m_err;
    logic [ID_W-1:0]  m_claim;
    logic [ID_W-1:0]  m_active;

    function automatic logic [VW-1:0] model_vec();
        return {m_irq, m_claim, m_active, m_pend, m_err};
    endfunction

    function automatic void model_reset();
        m_pend = '0; m_irq = 1'b0; m_err = 1'b0; m_claim = '0; m_active = '0;
    endfunction

    function automatic int ref_prio(int id);
        return int'(src_prio[(id-1)*PRIO_W +: PRIO_W]);
    endfunction

    function automatic int ref_winner();
        int best = 0;
        int bp = 0;
        for (int id = 1; id <= N_SRC; id++) begin
            if (m_pend[id-1] && src_enable[id-1] && ref_prio(id) > int'(threshold) && ref_prio(id) > bp) begin
                best = id;
                bp = ref_prio(id);
            end
        end
        return best;
    endfunction

    function automatic void model_step();
        int w;
        logic [N_SRC-1:0] np;
        logic ni, ne;
        logic [ID_W-1:0] nc, na;
        w = ref_winner();
        np = m_pend;
        for (int id = 1; id <= N_SRC; id++)
            if (src_level[id-1] && !m_pend[id-1] && int'(m_active) != id) np[id-1] = 1'b1;
        ni = m_irq; nc = m_claim; na = m_active; ne = 1'b0;
        if (m_active != 0) begin
            if (complete) begin
                if (complete_id == m_active) na = '0;
                else ne = 1'b1;
            end
        end else begin
            if (complete) ne = 1'b1;
            if (m_irq && claim) begin
                np[int'(m_claim)-1] = 1'b0;
                na = m_claim; ni = 1'b0; nc = '0;
            end else if (w != 0) begin
                ni = 1'b1; nc = ID_W'(w);
            end else begin
                ni = 1'b0; nc = '0;
            end
        end
        m_pend = np; m_irq = ni; m_claim = nc; m_active = na; m_err = ne;
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (nRST) model_step();
        #1;
    endtask

    task automatic show(input string name);
        $display("FAIL %s t=%0t got irq=%0b claim_id=%0d active_id=%0d pending=%h cmpl_err=%0b exp irq=%0b claim_id=%0d active_id=%0d pending=%h cmpl_err=%0b",
                 name, $time, irq, claim_id, active_id, pending, cmpl_err,
                 m_irq, m_claim, m_active, m_pend, m_err);
    endtask

    task automatic set_prio(input int id, input int p);
        src_prio[id*PRIO_W-1 -: PRIO_W] = PRIO_W'(p);
    endtask

    task automatic do_reset();
        src_level = '0; src_enable = '1; src_prio = '0; threshold = '0;
        claim = 1'b0; complete = 1'b0; complete_id = '0;
        nRST = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic test_reset();
        src_enable = '1;
        #3;
        tests_run++;
        if (dut_vec !== '0) begin tests_failed++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
        do_reset();
        repeat (3) tick();
        tests_run++;
        if (dut_vec !== model_vec()) begin tests_failed++; show("reset_idle"); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_latency();
        do_reset();
        set_prio(3, 2);
        src_level[2] = 1'b1;
        tick();
        tests_run++;
        if (pending !== 8'h04 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL lat_pending got pending=%h irq=%0b exp pending=04 irq=0", pending, irq);
        end
        tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd3) begin
            tests_failed++; $display("FAIL lat_irq got irq=%0b claim_id=%0d exp irq=1 claim_id=3", irq, claim_id);
        end
        tests_run++;
        if (dut_vec !== model_vec()) begin tests_failed++; show("lat_model"); end
        $display("[TB] test_latency done");
    endtask

    task automatic test_tie();
        do_reset();
        set_prio(2, 5); set_prio(6, 5);
        src_level = 8'h22;
        tick(); tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd2) begin
            tests_failed++; $display("FAIL tie_winner got irq=%0b claim_id=%0d exp irq=1 claim_id=2", irq, claim_id);
        end
        src_level = '0;
        claim = 1'b1; tick(); claim = 1'b0;
        tests_run++;
        if (active_id !== 4'd2 || irq !== 1'b0 || pending !== 8'h20) begin
            tests_failed++; $display("FAIL tie_claim got active_id=%0d irq=%0b pending=%h exp 2 0 20", active_id, irq, pending);
        end
        complete = 1'b1; complete_id = 4'd2; tick(); complete = 1'b0;
        tests_run++;
        if (dut_vec !== model_vec()) begin tests_failed++; show("tie_complete"); end
        tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd6) begin
            tests_failed++; $display("FAIL tie_next got irq=%0b claim_id=%0d exp irq=1 claim_id=6", irq, claim_id);
        end
        $display("[TB] test_tie done");
    endtask

    task automatic test_threshold();
        do_reset();
        set_prio(4, 3); threshold = 3'd3;
        src_level[3] = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (irq !== 1'b0 || claim_id !== 4'd0 || pending !== 8'h08) begin
            tests_failed++; $display("FAIL thr_block got irq=%0b claim_id=%0d pending=%h exp 0 0 08", irq, claim_id, pending);
        end
        threshold = 3'd2; tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd4) begin
            tests_failed++; $display("FAIL thr_lower got irq=%0b claim_id=%0d exp irq=1 claim_id=4", irq, claim_id);
        end
        threshold = 3'd3; tick();
        tests_run++;
        if (irq !== 1'b0 || claim_id !== 4'd0) begin
            tests_failed++; $display("FAIL thr_raise got irq=%0b claim_id=%0d exp irq=0 claim_id=0", irq, claim_id);
        end
        tests_run++;
        if (dut_vec !== model_vec()) begin tests_failed++; show("thr_model"); end
        $display("[TB] test_threshold done");
    endtask

    task automatic test_cmpl_err();
        do_reset();
        set_prio(5, 4);
        src_level[4] = 1'b1;
        complete = 1'b1; complete_id = 4'd5; tick(); complete = 1'b0;
        tests_run++;
        if (cmpl_err !== 1'b1) begin tests_failed++; $display("FAIL err_idle got cmpl_err=%0b exp 1", cmpl_err); end
        tick();
        complete = 1'b1; complete_id = 4'd5; tick(); complete = 1'b0;
        tests_run++;
        if (cmpl_err !== 1'b1 || irq !== 1'b1 || claim_id !== 4'd5 || active_id !== 4'd0) begin
            tests_failed++; $display("FAIL err_req got cmpl_err=%0b irq=%0b claim_id=%0d active_id=%0d exp 1 1 5 0", cmpl_err, irq, claim_id, active_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (active_id !== 4'd5 || pending !== 8'h00 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL err_nodup got active_id=%0d pending=%h irq=%0b exp 5 00 0", active_id, pending, irq);
        end
        complete = 1'b1; complete_id = 4'd4; tick(); complete = 1'b0;
        tests_run++;
        if (cmpl_err !== 1'b1 || active_id !== 4'd5) begin
            tests_failed++; $display("FAIL err_mismatch got cmpl_err=%0b active_id=%0d exp 1 5", cmpl_err, active_id);
        end
        complete = 1'b1; complete_id = 4'd5; tick(); complete = 1'b0;
        tests_run++;
        if (cmpl_err !== 1'b0 || active_id !== 4'd0) begin
            tests_failed++; $display("FAIL err_match got cmpl_err=%0b active_id=%0d exp 0 0", cmpl_err, active_id);
        end
        tick();
        tests_run++;
        if (pending !== 8'h10 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL err_repend got pending=%h irq=%0b exp 10 0", pending, irq);
        end
        tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd5) begin
            tests_failed++; $display("FAIL err_redeliver got irq=%0b claim_id=%0d exp 1 5", irq, claim_id);
        end
        $display("[TB] test_cmpl_err done");
    endtask

    task automatic test_preempt();
        do_reset();
        set_prio(1, 1); set_prio(7, 6);
        src_level[0] = 1'b1;
        tick(); tick();
        src_level[6] = 1'b1; tick();
        tests_run++;
        if (claim_id !== 4'd1 || pending !== 8'h41) begin
            tests_failed++; $display("FAIL pre_arrive got claim_id=%0d pending=%h exp 1 41", claim_id, pending);
        end
        tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd7) begin
            tests_failed++; $display("FAIL pre_switch got irq=%0b claim_id=%0d exp 1 7", irq, claim_id);
        end
        claim = 1'b1; tick(); claim = 1'b0;
        src_level[6] = 1'b0;
        complete = 1'b1; complete_id = 4'd7; tick(); complete = 1'b0;
        tick();
        tests_run++;
        if (claim_id !== 4'd1 || irq !== 1'b1) begin
            tests_failed++; $display("FAIL pre_back got irq=%0b claim_id=%0d exp 1 1", irq, claim_id);
        end
        src_level[6] = 1'b1; tick();
        claim = 1'b1; tick(); claim = 1'b0;
        tests_run++;
        if (active_id !== 4'd1 || claim_id !== 4'd0 || pending !== 8'h40) begin
            tests_failed++; $display("FAIL pre_grant got active_id=%0d claim_id=%0d pending=%h exp 1 0 40", active_id, claim_id, pending);
        end
        tests_run++;
        if (dut_vec !== model_vec()) begin tests_failed++; show("pre_model"); end
        $display("[TB] test_preempt done");
    endtask

    task automatic test_reset_service();
        do_reset();
        set_prio(2, 3); set_prio(8, 2);
        src_level = 8'h82;
        tick(); tick();
        claim = 1'b1; tick(); claim = 1'b0;
        tick();
        #2 nRST = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (dut_vec !== '0) begin tests_failed++; $display("FAIL rst_async got=%h exp=0", dut_vec); end
        @(posedge CLK); #1 nRST = 1'b1;
        tick();
        tests_run++;
        if (pending !== 8'h82 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL rst_repend got pending=%h irq=%0b exp 82 0", pending, irq);
        end
        tick();
        tests_run++;
        if (irq !== 1'b1 || claim_id !== 4'd2 || active_id !== 4'd0) begin
            tests_failed++; $display("FAIL rst_redeliver got irq=%0b claim_id=%0d active_id=%0d exp 1 2 0", irq, claim_id, active_id);
        end
        $display("[TB] test_reset_service done");
    endtask

    task automatic test_random();
        int local_fail;
        local_fail = 0;
        do_reset();
        src_prio = PW'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) src_level = N_SRC'($urandom);
            if ($urandom_range(0, 15) == 0) src_enable = N_SRC'($urandom) | N_SRC'($urandom);
            if ($urandom_range(0, 31) == 0) src_prio = PW'($urandom);
            if ($urandom_range(0, 31) == 0) threshold = PRIO_W'($urandom_range(0, 3));
            claim = (m_irq || $urandom_range(0, 9) == 0) && ($urandom_range(0, 2) == 0);
            complete = 1'b0;
            complete_id = '0;
            if (m_active != 0 && $urandom_range(0, 3) == 0) begin
                complete = 1'b1;
                complete_id = ($urandom_range(0, 4) != 0) ? m_active : ID_W'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                complete = 1'b1;
                complete_id = ID_W'($urandom);
            end
            tick();
            tests_run++;
            if (dut_vec !== model_vec()) begin
                tests_failed++;
                local_fail++;
                if (local_fail <= 10) show("random");
            end
        end
        claim = 1'b0; complete = 1'b0;
        $display("[TB] test_random done, %0d cycle mismatches", local_fail);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_tie();
        test_threshold();
        test_cmpl_err();
        test_preempt();
        test_reset_service();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
